// File: rtl/dct_butterfly_stage.sv
// DCT butterfly stage: buffers N-point frames in a ping-pong memory and
// streams out the N/2 mirrored sums followed by the N/2 mirrored differences.
// Both sides use valid/ready handshakes and sustain one sample per cycle.
module dct_butterfly_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_sample,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH:0]   out_sample,
  output logic                         out_first,
  output logic                         out_last
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Sign-extend one sample to the result width so add/subtract is exact.
  function automatic logic signed [DATA_WIDTH:0] sext(input logic signed [DATA_WIDTH-1:0] v);
    return {v[DATA_WIDTH-1], v};
  endfunction

  // Mirrored butterfly: sum for the first half of a frame, difference after.
  function automatic logic signed [DATA_WIDTH:0] butterfly(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b,
    input logic                         diff
  );
    logic signed [DATA_WIDTH:0] r;
    if (diff) r = sext(a) - sext(b);
    else      r = sext(a) + sext(b);
    return r;
  endfunction

  logic signed [DATA_WIDTH-1:0] bank_mem [2][N];
  logic [1:0]    full;
  logic          wr_bank, rd_bank;
  logic [CW-1:0] wr_cnt, rd_cnt;

  logic                         accept;
  logic                         wr_last;
  logic                         load;
  logic                         load_last;
  logic [CW-1:0]                idx_a_p0, idx_b_p0;
  logic                         diff_p0;
  logic signed [DATA_WIDTH-1:0] opa_p0, opb_p0;

  logic                         vld_p1;
  logic signed [DATA_WIDTH:0]   res_p1;
  logic                         first_p1, last_p1;

  // A bank is writable when empty, or when the reader frees it this very cycle.
  assign load      = full[rd_bank] && (!vld_p1 || out_ready);
  assign load_last = load && (rd_cnt == LAST);
  assign in_ready  = !full[wr_bank] || ((rd_bank == wr_bank) && load_last);
  assign accept    = in_valid && in_ready;
  assign wr_last   = accept && (wr_cnt == LAST);

  // ---- stage p0: operand selection from the bank being read ----
  // Upper half of k reuses the lower-half mirror pair as j = k - N/2.
  always_comb begin
    diff_p0  = rd_cnt[CW-1];
    idx_a_p0 = {1'b0, rd_cnt[CW-2:0]};
    idx_b_p0 = LAST - idx_a_p0;
    opa_p0   = bank_mem[rd_bank][idx_a_p0];
    opb_p0   = bank_mem[rd_bank][idx_b_p0];
  end

  // Sample storage; contents are never reset, only the control around them.
  always_ff @(posedge clk) begin
    if (accept) bank_mem[wr_bank][wr_cnt] <= in_sample;
  end

  // Write-side pointer and bank selection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (accept) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (wr_cnt == LAST) wr_bank <= ~wr_bank;
    end
  end

  // Read-side pointer and bank selection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else if (load) begin
      rd_cnt <= rd_cnt + 1'b1;
      if (rd_cnt == LAST) rd_bank <= ~rd_bank;
    end
  end

  // Bank full flags: release and completion are independent; a set wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      if (load_last) full[rd_bank] <= 1'b0;
      if (wr_last)   full[wr_bank] <= 1'b1;
    end
  end

  // ---- stage p1: registered output, held while downstream stalls ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      res_p1   <= '0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
    end else if (load) begin
      vld_p1   <= 1'b1;
      res_p1   <= butterfly(opa_p0, opb_p0, diff_p0);
      first_p1 <= (rd_cnt == '0);
      last_p1  <= (rd_cnt == LAST);
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid  = vld_p1;
  assign out_sample = res_p1;
  assign out_first  = first_p1;
  assign out_last   = last_p1;

endmodule

// File: tb/tb_dct_butterfly_stage.sv
// Testbench for dct_butterfly_stage: table vectors, directed stall/reset
// sequences, and randomized handshakes against a frame-level reference model.
module tb_dct_butterfly_stage;

  localparam int DW = 16;
  localparam int NP = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_sample = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [DW:0]   out_sample;
  logic                 out_first;
  logic                 out_last;

  dct_butterfly_stage #(.DATA_WIDTH(DW), .N(NP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .out_first  (out_first),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint v;
    bit     f;
    bit     l;
    int     cyc;
  } obs_t;

  typedef struct packed {
    logic [NP-1:0][DW-1:0] x;
    logic [NP-1:0][DW:0]   y;
  } vec_t;

  int     checks = 0;
  int     passes = 0;
  int     stall_cnt = 0;
  int     cyc = 0;
  bit     done = 1'b0;
  longint frame_q[$];
  obs_t   exp_q[$];
  obs_t   got_q[$];
  obs_t   o_obs, e_obs;
  bit     stall_prev = 1'b0;
  longint held_v;
  bit     held_f, held_l;
  vec_t   vecs [3];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: collect whole frames, then list the mirrored sums and differences.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      frame_q.delete();
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sample", out_sample, held_v);
        chk("hold_flags", {out_first, out_last}, {held_f, held_l});
      end
      if (out_valid && out_ready) begin
        o_obs.v = out_sample; o_obs.f = out_first; o_obs.l = out_last; o_obs.cyc = cyc;
        got_q.push_back(o_obs);
        chk("exp_available", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e_obs = exp_q.pop_front();
          chk("model_sample", out_sample, e_obs.v);
          chk("model_first", out_first, e_obs.f);
          chk("model_last", out_last, e_obs.l);
        end
      end
      stall_prev = out_valid && !out_ready;
      held_v = out_sample; held_f = out_first; held_l = out_last;
      if (in_valid && in_ready) begin
        frame_q.push_back(in_sample);
        if (frame_q.size() == NP) begin
          for (int k = 0; k < NP; k++) begin
            if (k < NP/2) e_obs.v = frame_q[k] + frame_q[NP-1-k];
            else          e_obs.v = frame_q[k-NP/2] - frame_q[NP-1-(k-NP/2)];
            e_obs.f = (k == 0); e_obs.l = (k == NP-1); e_obs.cyc = 0;
            exp_q.push_back(e_obs);
          end
          frame_q.delete();
        end
      end
    end
  end

  task automatic send(input longint v, input bit rnd);
    bit acc;
    int guard;
    guard = 0;
    in_sample = v[DW-1:0];
    do begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) stall_cnt++;
      @(posedge clk); #1;
      guard++;
      if (guard > 2000) begin
        $display("FAIL send_timeout: got %0d cycles without accept, expected < 2000", guard);
        $fatal(1);
      end
    end while (!acc);
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input string name);
    int g;
    g = 0;
    while (got_q.size() < n && g < 5000) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk(name, got_q.size(), n);
  endtask

  initial begin
    for (int i = 0; i < NP; i++) begin
      vecs[0].x[i] = 16'(i);
      vecs[0].y[i] = (i < 8) ? 17'sd15 : 17'(2*(i-8) - 15);
      vecs[1].x[i] = (i < 8) ? 16'h7FFF : 16'h8000;
      vecs[1].y[i] = (i < 8) ? 17'h1FFFF : 17'h0FFFF;
      vecs[2].x[i] = 16'h8000;
      vecs[2].y[i] = (i < 8) ? 17'h10000 : 17'h00000;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_sample", out_sample, 0);
    chk("reset_flags", {out_first, out_last}, 0);
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors: ramp and the two 17-bit extremes.
    for (int v = 0; v < 3; v++) begin
      got_q.delete();
      out_ready = 1'b1;
      for (int i = 0; i < NP; i++) send(longint'($signed(vecs[v].x[i])), 1'b0);
      chk("latency_pre", out_valid, 0);
      @(posedge clk); #1;
      chk("latency_valid", out_valid, 1);
      wait_got(NP, "vec_count");
      if (got_q.size() == NP) begin
        for (int k = 0; k < NP; k++) begin
          chk("vec_sample", got_q[k].v, longint'($signed(vecs[v].y[k])));
          chk("vec_first", got_q[k].f, k == 0);
          chk("vec_last", got_q[k].l, k == NP-1);
        end
      end
    end

    // Four frames back-to-back: no bubbles on either side.
    got_q.delete();
    stall_cnt = 0;
    for (int i = 0; i < 4*NP; i++) send(longint'($signed(16'($urandom))), 1'b0);
    chk("4f_in_stalls", stall_cnt, 0);
    wait_got(4*NP, "4f_count");
    if (got_q.size() == 4*NP) chk("4f_out_span", got_q[4*NP-1].cyc - got_q[0].cyc, 4*NP-1);

    // Downstream stalled from the start with two frames sent.
    repeat (4) @(posedge clk);
    #1;
    got_q.delete();
    out_ready = 1'b0;
    stall_cnt = 0;
    for (int i = 0; i < 2*NP; i++) send(i % NP, 1'b0);
    chk("stall_in_stalls", stall_cnt, 0);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_out_sample", out_sample, 15);
    chk("stall_out_first", out_first, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_in_ready_hold", in_ready, 0);
    out_ready = 1'b1;
    begin
      int rel;
      rel = 40;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (in_ready) begin
          rel = i;
          break;
        end
      end
      chk("stall_release_cycle", rel, 14);
    end
    wait_got(2*NP, "stall_drain_count");
    if (got_q.size() > 0) chk("stall_drain_first", got_q[0].v, 15);

    // Random valid/ready toggling over 20 frames.
    got_q.delete();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20*NP; i++) send(longint'($signed(16'($urandom))), 1'b1);
        wait_got(20*NP, "rand_count");
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    chk("rand_model_empty", exp_q.size(), 0);

    // Reset with one frame buffered and 7 samples of the next.
    out_ready = 1'b0;
    for (int i = 0; i < NP + 7; i++) send(i % NP, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_reset_out_valid", out_valid, 0);
    chk("mid_reset_out_sample", out_sample, 0);
    chk("mid_reset_flags", {out_first, out_last}, 0);
    chk("mid_reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < NP; i++) send(i, 1'b0);
    wait_got(NP, "post_reset_count");
    repeat (20) @(posedge clk);
    #1;
    chk("post_reset_no_residual", got_q.size(), NP);
    if (got_q.size() >= NP) begin
      for (int k = 0; k < NP; k++) begin
        chk("post_reset_sample", got_q[k].v, longint'($signed(vecs[0].y[k])));
        chk("post_reset_flags", {got_q[k].f, got_q[k].l}, {k == 0, k == NP-1});
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dct_butterfly_stage.md
Name: dct_butterfly_stage

Overview:
- Parametrised successor to the single-register DCT pipeline stage.
- Accepts a serial stream of N-point frames, buffers each frame in a ping-pong memory, and emits the butterfly outputs serially: first the N/2 mirrored sums, then the N/2 mirrored differences.
- Uses valid/ready handshakes on both sides and sustains 1 sample/cycle.
- Sits between the input reorder stage and the CORDIC rotation stages of the DCT pipeline.

Parameters:
- DATA_WIDTH, 16, input sample width (signed two's complement).
- N, 16, frame length in points. Power of 2, at least 4.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, input sample valid.
- in_ready, output, 1, stage can accept a sample.
- in_sample, input, DATA_WIDTH, signed input sample x[i]. Frame order is i = 0..N-1.
- out_valid, output, 1, output sample valid (registered).
- out_ready, input, 1, downstream accepts the output.
- out_sample, output, DATA_WIDTH+1, signed butterfly result (registered).
- out_first, output, 1, high with result k=0 of a frame (registered).
- out_last, output, 1, high with result k=N-1 of a frame (registered).

Behaviour:
- Interface decision: reset rst_n, synchronous, active-low; clock clk. All state updates on the rising edge of clk.
- Reset values: out_valid=0, out_sample=0, out_first=0, out_last=0. Both bank full flags=0, wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0.
  - Bank contents need not be reset.
  - Reset mid-frame discards all partial and buffered frames. The first sample accepted after reset is x[0] of a new frame.
- Storage: two banks of N x DATA_WIDTH. Each bank has a full flag.
- Write side:
  - A sample is accepted on an edge where in_valid and in_ready are both high.
  - It is written to bank[wr_bank][wr_cnt], and wr_cnt increments.
  - When wr_cnt = N-1 is accepted: set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
- Read side:
  - Output register loads when full[rd_bank]=1 and (out_valid=0 or out_ready=1).
  - Result for k = rd_cnt:
    - k < N/2: x[k] + x[N-1-k].
    - k >= N/2: with j = k-N/2, x[j] - x[N-1-j].
  - Operands are sign-extended to DATA_WIDTH+1 before the add/subtract. The result is exact; no saturation or rounding.
  - out_first is set when k=0; out_last is set when k=N-1.
  - On loading k=N-1: clear full[rd_bank], toggle rd_bank, rd_cnt wraps to 0.
- out_valid:
  - Falls when out_ready=1 and no new load occurs.
  - While out_valid=1 and out_ready=0, out_sample, out_first and out_last hold stable.
- in_ready:
  - in_ready = !full[wr_bank], OR (rd_bank == wr_bank AND the k=N-1 load occurs this cycle).
  - This is a documented combinational path from out_ready to in_ready.
  - On that shared edge, the read uses the old bank contents and the write lands after it; no data hazard.
- Latency: out_valid rises on the edge after the edge that accepts x[N-1] of a frame, provided the output register is free.
- Throughput: with in_valid=1 and out_ready=1 continuously, no bubbles on either side.
- Simultaneous bank completion on the write side and bank release on the read side are independent and both take effect on the same edge.
- With two frames buffered, in_ready=0 until the read side releases a bank.

Test Plan:
- N=16, in = 0..15 back-to-back, out_ready=1 -> 1 cycle after x[15] is accepted: 8 outputs of 15, then -15,-13,-11,-9,-7,-5,-3,-1. out_first is set on the first output and out_last on the last.
- Extremes: x[0..7]=32767, x[8..15]=-32768 -> sums all -1; differences all 65535. Then all samples -32768 -> sums -65536, differences 0. Checks the 17-bit range with no overflow.
- 4 consecutive frames streamed with in_valid=1 and out_ready=1 -> in_ready stays 1 and out_valid stays 1 from the first output to the final one. 64 outputs in order, ping-pong wraps twice.
- out_ready=0 from the start and two frames sent -> out_valid=1 holding 15 with out_first=1. in_ready drops after the 32nd accept. Raising out_ready then drains 32 correct results, and in_ready returns on the release edge of the first frame.
- Random in_valid/out_ready toggling (~50%) over 20 frames -> outputs match the reference model exactly. No handshake drops or duplicates, and outputs hold stable while stalled.
- Assert rst_n=0 after 7 samples of a frame and with one frame buffered -> outputs are at reset values on the next edge. A fresh frame 0..15 afterwards yields exactly the first-scenario sequence with no residual outputs.
